// File: rtl/sim_lane_mem_responder_if.sv
// Request/response bundle for the multi-lane memory responder.
// Lane i of every packed field occupies slice [W*i +: W]; the master drives
// requests and accepts responses, the slave (the responder) does the reverse.
interface sim_lane_mem_responder_if #(
    parameter int NUM_LANES     = 4,
    parameter int DATA_WIDTH    = 64,
    parameter int LOGSIZE_WIDTH = 3
);
    logic [NUM_LANES-1:0]               a_valid;
    logic [NUM_LANES-1:0]               a_ready;
    logic [DATA_WIDTH*NUM_LANES-1:0]    a_address;
    logic [NUM_LANES-1:0]               a_is_store;
    logic [LOGSIZE_WIDTH*NUM_LANES-1:0] a_size;
    logic [DATA_WIDTH*NUM_LANES-1:0]    a_data;

    logic [NUM_LANES-1:0]               d_valid;
    logic [NUM_LANES-1:0]               d_ready;
    logic [NUM_LANES-1:0]               d_is_store;
    logic [LOGSIZE_WIDTH*NUM_LANES-1:0] d_size;
    logic [DATA_WIDTH*NUM_LANES-1:0]    d_data;

    logic                               inflight;

    modport master (
        output a_valid, a_address, a_is_store, a_size, a_data, d_ready,
        input  a_ready, d_valid, d_is_store, d_size, d_data, inflight
    );

    modport slave (
        input  a_valid, a_address, a_is_store, a_size, a_data, d_ready,
        output a_ready, d_valid, d_is_store, d_size, d_data, inflight
    );
endinterface

// File: rtl/sim_lane_mem_responder.sv
// Multi-lane simulation memory responder.
// Each lane accepts load/store requests into a fixed-latency pipeline that
// drains into a per-lane response FIFO; all lanes share one backing memory.
// Loads see memory as it was before the accept edge; overlapping same-cycle
// stores resolve with the highest lane winning each byte.
// Optional feature macro: SIMMEM_RANDOM_STALL_EN adds LFSR-driven a_ready stalls.
module sim_lane_mem_responder #(
    parameter int NUM_LANES     = 4,
    parameter int DATA_WIDTH    = 64,
    parameter int LOGSIZE_WIDTH = 3,
    parameter int MEM_WORDS     = 1024,
    parameter int LATENCY       = 4,
    parameter int DEPTH         = 4
) (
    input logic                     clock,
    input logic                     reset,
    sim_lane_mem_responder_if.slave bus
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic                     is_store;
        logic [LOGSIZE_WIDTH-1:0] size;
        logic [DATA_WIDTH-1:0]    data;
    } resp_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic [CNT_W-1:0]   out_cnt  [NUM_LANES];
    logic [LATENCY-1:0] pipe_vld [NUM_LANES];
    resp_t              pipe     [NUM_LANES][LATENCY];
    resp_t              fifo     [NUM_LANES][DEPTH];
    logic [PTR_W-1:0]   rd_ptr   [NUM_LANES];
    logic [PTR_W-1:0]   wr_ptr   [NUM_LANES];
    logic [CNT_W-1:0]   fifo_cnt [NUM_LANES];

    logic [NUM_LANES-1:0] stall_ok;
    logic [NUM_LANES-1:0] a_ready_w;
    logic [NUM_LANES-1:0] accept;
    logic [NUM_LANES-1:0] take;
    logic [IDX_W-1:0]     word_idx  [NUM_LANES];
    logic [BYTES-1:0]     byte_en   [NUM_LANES];
    resp_t                new_entry [NUM_LANES];
    logic                 addr_unused;

    logic [NUM_LANES-1:0]               d_valid_w;
    logic [NUM_LANES-1:0]               d_is_store_w;
    logic [LOGSIZE_WIDTH*NUM_LANES-1:0] d_size_w;
    logic [DATA_WIDTH*NUM_LANES-1:0]    d_data_w;
    logic                               inflight_w;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef SIMMEM_RANDOM_STALL_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) that throttles a_ready
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Each lane may only accept while its LFSR bit is set
    always_comb begin
        stall_ok = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            stall_ok[i] = lfsr[i % 16];
        end
    end
`else
    // No stall source: readiness depends only on free capacity
    always_comb begin
        stall_ok = '1;
    end
`endif

    // Request decode: readiness, accept, word index and store byte enables
    always_comb begin
        logic [DATA_WIDTH-1:0]    addr;
        logic [LOGSIZE_WIDTH-1:0] sz;
        int                       off;
        int                       nbytes;
        addr        = '0;
        sz          = '0;
        off         = 0;
        nbytes      = 0;
        a_ready_w   = '0;
        accept      = '0;
        addr_unused = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            addr   = bus.a_address[DATA_WIDTH*i +: DATA_WIDTH];
            sz     = bus.a_size[LOGSIZE_WIDTH*i +: LOGSIZE_WIDTH];
            off    = int'(addr[OFF_W-1:0]);
            nbytes = (int'(sz) > OFF_W) ? BYTES : (1 << sz);
            a_ready_w[i] = reset && (out_cnt[i] < CNT_W'(DEPTH)) && stall_ok[i];
            accept[i]    = bus.a_valid[i] && a_ready_w[i];
            word_idx[i]  = addr[OFF_W +: IDX_W];
            addr_unused  = addr_unused ^ (^addr[DATA_WIDTH-1:OFF_W+IDX_W]);
            for (int b = 0; b < BYTES; b++) begin
                byte_en[i][b] = (b >= off) && (b < off + nbytes);
            end
            new_entry[i].is_store = bus.a_is_store[i];
            new_entry[i].size     = sz;
            new_entry[i].data     = bus.a_is_store[i] ? '0 : mem[word_idx[i]];
        end
    end

    // Present the head of each response FIFO, zeroed when the FIFO is empty
    always_comb begin
        d_valid_w    = '0;
        d_is_store_w = '0;
        d_size_w     = '0;
        d_data_w     = '0;
        inflight_w   = 1'b0;
        take         = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (fifo_cnt[i] != '0) begin
                d_valid_w[i]                                   = 1'b1;
                d_is_store_w[i]                                = fifo[i][rd_ptr[i]].is_store;
                d_size_w[LOGSIZE_WIDTH*i +: LOGSIZE_WIDTH]     = fifo[i][rd_ptr[i]].size;
                d_data_w[DATA_WIDTH*i +: DATA_WIDTH]           = fifo[i][rd_ptr[i]].data;
            end
            take[i]    = d_valid_w[i] && bus.d_ready[i];
            inflight_w = inflight_w || (out_cnt[i] != '0);
        end
    end

    assign bus.a_ready    = a_ready_w;
    assign bus.d_valid    = d_valid_w;
    assign bus.d_is_store = d_is_store_w;
    assign bus.d_size     = d_size_w;
    assign bus.d_data     = d_data_w;
    assign bus.inflight   = inflight_w;

    // Backing store writes; later (higher) lanes override earlier ones per byte
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (accept[i] && bus.a_is_store[i]) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (byte_en[i][b]) begin
                        mem[word_idx[i]][8*b +: 8] <= bus.a_data[DATA_WIDTH*i + 8*b +: 8];
                    end
                end
            end
        end
    end

    // Per-lane outstanding count, latency pipeline and response FIFO
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                out_cnt[i]  <= '0;
                pipe_vld[i] <= '0;
                rd_ptr[i]   <= '0;
                wr_ptr[i]   <= '0;
                fifo_cnt[i] <= '0;
                for (int s = 0; s < LATENCY; s++) begin
                    pipe[i][s] <= '0;
                end
                for (int d = 0; d < DEPTH; d++) begin
                    fifo[i][d] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (accept[i] && !take[i]) begin
                    out_cnt[i] <= out_cnt[i] + CNT_W'(1);
                end else if (!accept[i] && take[i]) begin
                    out_cnt[i] <= out_cnt[i] - CNT_W'(1);
                end
                pipe_vld[i][0] <= accept[i];
                pipe[i][0]     <= new_entry[i];
                for (int s = 1; s < LATENCY; s++) begin
                    pipe_vld[i][s] <= pipe_vld[i][s-1];
                    pipe[i][s]     <= pipe[i][s-1];
                end
                if (pipe_vld[i][LATENCY-1]) begin
                    fifo[i][wr_ptr[i]] <= pipe[i][LATENCY-1];
                    wr_ptr[i]          <= ptr_next(wr_ptr[i]);
                end
                if (take[i]) begin
                    rd_ptr[i] <= ptr_next(rd_ptr[i]);
                end
                if (pipe_vld[i][LATENCY-1] && !take[i]) begin
                    fifo_cnt[i] <= fifo_cnt[i] + CNT_W'(1);
                end else if (!pipe_vld[i][LATENCY-1] && take[i]) begin
                    fifo_cnt[i] <= fifo_cnt[i] - CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_sim_lane_mem_responder.sv
// Scoreboard bench for sim_lane_mem_responder (default build).
// The driver models memory as a flat byte array and pushes expected responses
// (with their accept cycle) into per-lane queues; an independent monitor pops
// and compares whenever a lane presents d_valid.
module tb_sim_lane_mem_responder;
    localparam int NL        = 4;
    localparam int DW        = 64;
    localparam int LW        = 3;
    localparam int MW        = 1024;
    localparam int LAT       = 4;
    localparam int DEPTH     = 4;
    localparam int MEM_BYTES = MW * 8;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    sim_lane_mem_responder_if #(.NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(LW)) bus ();

    sim_lane_mem_responder #(
        .NUM_LANES(NL), .DATA_WIDTH(DW), .LOGSIZE_WIDTH(LW),
        .MEM_WORDS(MW), .LATENCY(LAT), .DEPTH(DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          is_store;
        logic [LW-1:0] size;
        logic [DW-1:0] data;
        int            acc;
    } exp_t;

    exp_t       exp_q [NL][$];
    logic [7:0] ref_mem [MEM_BYTES];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit head_seen [NL];
    int last_pop  [NL];

    logic [NL-1:0] stim_valid;
    logic [NL-1:0] stim_store;
    logic [NL-1:0] stim_d_ready;
    logic [NL-1:0] last_accept;
    logic [DW-1:0] stim_addr [NL];
    logic [DW-1:0] stim_data [NL];
    logic [LW-1:0] stim_size [NL];

    exp_t mon_e;
    int   mon_due;

    // Cycle counter: value N means N rising edges have occurred
    always @(posedge clock) cyc++;

    task automatic check_output(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [DW-1:0] model_load(input logic [DW-1:0] addr);
        logic [DW-1:0] w;
        int            base;
        base = int'(addr % 64'(MEM_BYTES));
        base = base - (base % 8);
        for (int k = 0; k < 8; k++) w[8*k +: 8] = ref_mem[base + k];
        return w;
    endfunction

    function automatic void model_store(input logic [DW-1:0] addr, input logic [LW-1:0] size,
                                        input logic [DW-1:0] data);
        int a;
        int off;
        int n;
        a   = int'(addr % 64'(MEM_BYTES));
        off = a % 8;
        n   = (int'(size) > 3) ? 8 : (1 << size);
        for (int k = 0; k < n; k++) begin
            if (off + k < 8) ref_mem[a + k] = data[8*(off + k) +: 8];
        end
    endfunction

    function automatic int pending_count();
        int n;
        n = 0;
        for (int i = 0; i < NL; i++) n += exp_q[i].size();
        return n;
    endfunction

    task automatic clear_stim();
        stim_valid   = '0;
        stim_store   = '0;
        stim_d_ready = '1;
        for (int i = 0; i < NL; i++) begin
            stim_addr[i] = '0;
            stim_data[i] = '0;
            stim_size[i] = '0;
        end
    endtask

    // One cycle: drive at the falling edge, check readiness, then update the model
    task automatic apply_stimulus();
        logic [NL-1:0] exp_ready;
        logic          exp_inflight;
        exp_t          e;
        @(negedge clock);
        for (int i = 0; i < NL; i++) begin
            bus.a_address[DW*i +: DW] = stim_addr[i];
            bus.a_data[DW*i +: DW]    = stim_data[i];
            bus.a_size[LW*i +: LW]    = stim_size[i];
        end
        bus.a_valid    = stim_valid;
        bus.a_is_store = stim_store;
        bus.d_ready    = stim_d_ready;
        #1;
        exp_ready    = '0;
        exp_inflight = 1'b0;
        for (int i = 0; i < NL; i++) begin
            exp_ready[i] = (exp_q[i].size() < DEPTH);
            if (exp_q[i].size() != 0) exp_inflight = 1'b1;
        end
        check_output("a_ready", DW'(bus.a_ready), DW'(exp_ready));
        check_output("inflight", DW'(bus.inflight), DW'(exp_inflight));
        last_accept = stim_valid & exp_ready;
        for (int i = 0; i < NL; i++) begin
            if (last_accept[i] && !stim_store[i]) begin
                e.is_store = 1'b0; e.size = stim_size[i]; e.data = model_load(stim_addr[i]); e.acc = cyc + 1;
                exp_q[i].push_back(e);
            end
        end
        for (int i = 0; i < NL; i++) begin
            if (last_accept[i] && stim_store[i]) begin
                model_store(stim_addr[i], stim_size[i], stim_data[i]);
                e.is_store = 1'b1; e.size = stim_size[i]; e.data = '0; e.acc = cyc + 1;
                exp_q[i].push_back(e);
            end
        end
    endtask

    task automatic issue_one(input int lane, input logic st, input logic [DW-1:0] addr,
                             input logic [LW-1:0] size, input logic [DW-1:0] data);
        int n;
        n = 0;
        clear_stim();
        stim_valid[lane] = 1'b1;
        stim_store[lane] = st;
        stim_addr[lane]  = addr;
        stim_size[lane]  = size;
        stim_data[lane]  = data;
        do begin
            apply_stimulus();
            n++;
        end while (!last_accept[lane] && n < 50);
        check_output("issue_accepted", DW'(last_accept[lane]), 64'd1);
        clear_stim();
    endtask

    task automatic drain();
        int n;
        n = 0;
        clear_stim();
        while (pending_count() != 0 && n < 200) begin
            apply_stimulus();
            n++;
        end
        check_output("drain_empty", DW'(pending_count()), 64'd0);
    endtask

    task automatic do_reset(input int hold);
        @(negedge clock);
        reset       = 1'b0;
        bus.a_valid = '0;
        #1;
        check_output("rst_d_valid", DW'(bus.d_valid), 64'd0);
        check_output("rst_inflight", DW'(bus.inflight), 64'd0);
        check_output("rst_a_ready", DW'(bus.a_ready), 64'd0);
        check_output("rst_d_is_store", DW'(bus.d_is_store), 64'd0);
        check_output("rst_d_size", DW'(bus.d_size), 64'd0);
        for (int i = 0; i < NL; i++) begin
            check_output("rst_d_data", bus.d_data[DW*i +: DW], 64'd0);
            exp_q[i].delete();
            head_seen[i] = 1'b0;
            last_pop[i]  = 0;
        end
        repeat (hold) @(negedge clock);
        reset = 1'b1;
        #1;
        check_output("a_ready_after_reset", DW'(bus.a_ready), DW'({NL{1'b1}}));
    endtask

    // Monitor: compare every presented response against the queue head
    always @(negedge clock) begin
        #2;
        for (int i = 0; i < NL; i++) begin
            if (bus.d_valid[i]) begin
                if (exp_q[i].size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL spurious_d_valid lane %0d: got d_valid=1 expected 0 (cycle %0d)", i, cyc);
                end else begin
                    mon_e = exp_q[i][0];
                    if (!head_seen[i]) begin
                        mon_due = (mon_e.acc + LAT > last_pop[i]) ? mon_e.acc + LAT : last_pop[i];
                        check_output("d_valid_timing", DW'(cyc), DW'(mon_due));
                        head_seen[i] = 1'b1;
                    end
                    check_output("d_data", bus.d_data[DW*i +: DW], mon_e.data);
                    check_output("d_attr", DW'({bus.d_is_store[i], bus.d_size[LW*i +: LW]}),
                                 DW'({mon_e.is_store, mon_e.size}));
                    if (bus.d_ready[i]) begin
                        void'(exp_q[i].pop_front());
                        head_seen[i] = 1'b0;
                        last_pop[i]  = cyc + 1;
                    end
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int n;
        int sz;
        int al;
        int off;
        for (int b = 0; b < MEM_BYTES; b++) ref_mem[b] = 8'h00;
        for (int i = 0; i < NL; i++) begin
            head_seen[i] = 1'b0;
            last_pop[i]  = 0;
        end
        bus.a_valid = '0; bus.a_is_store = '0; bus.a_address = '0;
        bus.a_size  = '0; bus.a_data     = '0; bus.d_ready   = '0;
        clear_stim();
        last_accept = '0;

        do_reset(3);

        // Zero the words exercised below so loads never see uninitialised memory
        for (int w = 0; w <= 32; w++) issue_one(w % NL, 1'b1, 64'(w * 8), 3'd3, 64'd0);
        drain();

        // Full-word store then load on lane 0
        issue_one(0, 1'b1, 64'h40, 3'd3, 64'h1122334455667788);
        issue_one(0, 1'b0, 64'h40, 3'd3, 64'd0);
        drain();

        // Lane 1 burst of five loads against a stalled response channel
        clear_stim();
        stim_valid[1] = 1'b1;
        stim_size[1]  = 3'd3;
        stim_d_ready  = '0;
        acc = 0;
        n   = 0;
        while (acc < 5 && n < 40) begin
            if (n >= 10) stim_d_ready = '1;
            stim_addr[1] = 64'(8 * n);
            apply_stimulus();
            if (last_accept[1]) acc++;
            n++;
        end
        check_output("burst_accepts", DW'(acc), 64'd5);
        drain();

        // Same-cycle overlapping stores from lanes 0 and 3
        clear_stim();
        stim_valid = 4'b1001;
        stim_store = 4'b1001;
        stim_addr[0] = 64'h80; stim_size[0] = 3'd3; stim_data[0] = 64'hAAAAAAAAAAAAAAAA;
        stim_addr[3] = 64'h80; stim_size[3] = 3'd3; stim_data[3] = 64'hBBBBBBBBBBBBBBBB;
        apply_stimulus();
        check_output("dual_store_accept", DW'(last_accept), 64'h9);
        issue_one(2, 1'b0, 64'h80, 3'd3, 64'd0);
        drain();

        // Single-byte store and address aliasing
        issue_one(0, 1'b1, 64'h103, 3'd0, 64'h000000005A000000);
        issue_one(1, 1'b0, 64'h100, 3'd3, 64'd0);
        issue_one(2, 1'b0, 64'h2100, 3'd3, 64'd0);
        drain();

        // Reset with three requests outstanding; nothing may come out afterwards
        clear_stim();
        stim_valid = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            stim_addr[i] = 64'(8 * i);
            stim_size[i] = 3'd3;
        end
        apply_stimulus();
        do_reset(2);
        clear_stim();
        repeat (20) apply_stimulus();

        // Randomised traffic over a small, aliased address window
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NL; i++) begin
                stim_valid[i]   = ($urandom_range(0, 99) < 60);
                stim_store[i]   = 1'($urandom_range(0, 1));
                sz              = $urandom_range(0, 7);
                al              = (sz > 3) ? 8 : (1 << sz);
                off             = $urandom_range(0, 7);
                off             = off - (off % al);
                stim_size[i]    = LW'(sz);
                stim_addr[i]    = (64'($urandom) << 13) | 64'($urandom_range(0, 31) * 8 + off);
                stim_data[i]    = {$urandom, $urandom};
                stim_d_ready[i] = ($urandom_range(0, 99) < 70);
            end
            apply_stimulus();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sim_lane_mem_responder.md
SIM_LANE_MEM_RESPONDER -- requirements
Module: sim_lane_mem_responder

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4: number of independent request/response lanes.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: per-lane address and data width in bits.
REQ-003 SHALL have parameter LOGSIZE_WIDTH, default 3: per-lane log2 byte-size field width.
REQ-004 SHALL have parameter MEM_WORDS, default 1024 (power of 2): backing-store depth in DATA_WIDTH words.
REQ-005 SHALL have parameter LATENCY, default 4 (>=1): accept-to-response cycles.
REQ-006 SHALL have parameter DEPTH, default 4 (>=1): maximum outstanding requests per lane.
REQ-007 clock  in  1  sole clock; all state on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 a_valid  in  NUM_LANES  per-lane request valid.
REQ-010 a_ready  out  NUM_LANES  per-lane request ready.
REQ-011 a_address  in  DATA_WIDTH*NUM_LANES  per-lane byte address; lane i at bits [DATA_WIDTH*i +: DATA_WIDTH].
REQ-012 a_is_store  in  NUM_LANES  1 = store, 0 = load.
REQ-013 a_size  in  LOGSIZE_WIDTH*NUM_LANES  log2 access bytes.
REQ-014 a_data  in  DATA_WIDTH*NUM_LANES  store data, byte-lane aligned.
REQ-015 d_valid  out  NUM_LANES  per-lane response valid.
REQ-016 d_ready  in  NUM_LANES  per-lane response ready.
REQ-017 d_is_store  out  NUM_LANES  echo of request a_is_store.
REQ-018 d_size  out  LOGSIZE_WIDTH*NUM_LANES  echo of request a_size.
REQ-019 d_data  out  DATA_WIDTH*NUM_LANES  load data (full word); 0 for stores.
REQ-020 inflight  out  1  high while any lane has an outstanding request.

Function
REQ-021 Lane i SHALL accept a request on a rising edge where a_valid[i] and a_ready[i] are both high.
REQ-022 a_ready[i] SHALL be high iff lane i outstanding count < DEPTH (gated further per REQ-036); it SHALL NOT depend on a_valid.
REQ-023 Outstanding count SHALL increment on accept and decrement on d_valid&d_ready; simultaneous accept and release SHALL leave it unchanged.
REQ-024 Word index SHALL be address[log2(DATA_WIDTH/8) +: log2(MEM_WORDS)]; higher address bits ignored (wrap-around).
REQ-025 Store SHALL write, at the accept edge, the 2^size bytes starting at address mod (DATA_WIDTH/8), taken from the same byte lanes of a_data; size above log2(DATA_WIDTH/8) SHALL clamp to full word.
REQ-026 Load SHALL capture the whole word as it was before the accept edge; same-cycle stores from any lane SHALL NOT be visible to it.
REQ-027 Same-cycle stores to overlapping bytes SHALL resolve with the highest lane index winning per byte.
REQ-028 Each accepted request SHALL traverse a LATENCY-stage pipeline and then a per-lane response FIFO of DEPTH entries; FIFO SHALL never overflow (guaranteed by REQ-022).
REQ-029 With the lane idle and d_ready high, d_valid SHALL rise exactly LATENCY cycles after the accept edge.
REQ-030 Responses SHALL return in acceptance order per lane; lanes SHALL be fully independent except for memory sharing.
REQ-031 d_valid/d_is_store/d_size/d_data SHALL hold stable while d_valid high and d_ready low.
REQ-032 inflight SHALL be the OR over lanes of (outstanding count != 0), registered-free (combinational from counts).

Reset
REQ-033 While reset low: a_ready=0, d_valid=0, inflight=0, d_is_store=0, d_size=0, d_data=0; all counts, pipelines and FIFOs cleared.
REQ-034 Reset asserted mid-operation SHALL discard all outstanding requests without emitting responses; completed stores SHALL remain in memory.
REQ-035 Backing memory SHALL NOT be reset; first cycle after release a_ready SHALL equal all-ones (random-stall disabled).

Configuration
REQ-036 With SIMMEM_RANDOM_STALL_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11), reset value 0xACE1, advances every cycle; a_ready[i] additionally requires lfsr[i mod 16]=1. Without it: no LFSR, no gating.

Verification
REQ-037 Lane 0 store addr 0x40 size 3 data 0x1122334455667788, then load 0x40 -> d_data 0x1122334455667788, load d_valid exactly 4 cycles after its accept.
REQ-038 Lane 1 issues 5 back-to-back loads with d_ready=0 -> a_ready[1] drops after 4th accept; 5th accepted 1 cycle after first d_ready handshake.
REQ-039 Lanes 0 and 3 store 0xAA.. and 0xBB.. to 0x80 same cycle -> later load returns 0xBBBBBBBBBBBBBBBB.
REQ-040 Store addr 0x103 size 0 data byte3=0x5A into word previously 0 -> load 0x100 returns 0x000000005A000000; address 0x2100 (MEM_WORDS=1024) aliases 0x100.
REQ-041 Reset pulled low with 3 requests outstanding -> d_valid, inflight drop immediately; no responses after release; a_ready all-ones.
REQ-042 SIMMEM_RANDOM_STALL_EN build: cycle-1 a_ready equals low NUM_LANES bits of 0xACE1 (0x1) under count<DEPTH.
